// File: rtl/wlm_pkg.sv
// Shared sizing helpers for the word-level Montgomery reducer: iteration count,
// pipeline latency and datapath widths.
package wlm_pkg;

    localparam int WLM_DEF_LOGQ = 64;
    localparam int WLM_DEF_R    = 17;

    function automatic int wlm_calc_l(input int logq, input int r);
        return (logq + r - 1) / r;
    endfunction

    function automatic int wlm_calc_lat(input int l, input int ff_in, input int ff_mul,
                                        input int ff_sum, input int correct,
                                        input int ff_sub, input int ff_out);
        return ff_in + l * (ff_mul + ff_sum) + correct * ff_sub + ff_out;
    endfunction

    function automatic int wlm_acc_w(input int logq);
        return logq + 1;
    endfunction

    function automatic int wlm_qh_w(input int logq, input int r);
        return logq - r;
    endfunction

endpackage

// File: rtl/wlm_iter.sv
// One Montgomery word iteration: T <- (T + m*q) / 2^R with m = -T mod 2^R,
// computed as TH + m*qH + (TL != 0). qH rides along with its operand.
module wlm_iter
    import wlm_pkg::*;
#(
    parameter int LOGQ   = WLM_DEF_LOGQ,
    parameter int R      = WLM_DEF_R,
    parameter int W      = 2 * WLM_DEF_LOGQ,
    parameter int FF_MUL = 1,
    parameter int FF_SUM = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [W-1:0]                  t_in,
    input  logic [wlm_qh_w(LOGQ, R)-1:0]  qh_in,
    output logic [W-1:0]                  t_out,
    output logic [wlm_qh_w(LOGQ, R)-1:0]  qh_out
);

    logic [R-1:0]                 tl_p0;
    logic [R-1:0]                 m_p0;
    logic [W-R-1:0]               th_p0;
    logic [LOGQ-1:0]              prod_p0;
    logic                         nz_p0;

    assign tl_p0   = t_in[R-1:0];
    assign th_p0   = t_in[W-1:R];
    assign m_p0    = R'(0) - tl_p0;
    assign nz_p0   = |tl_p0;
    // m < 2^R and qH < 2^(LOGQ-R), so the product fits exactly in LOGQ bits
    assign prod_p0 = LOGQ'(m_p0) * LOGQ'(qh_in);

    // ---- stage p1: after the m*qH multiply ----
    logic [W-R-1:0]               th_p1;
    logic [LOGQ-1:0]              prod_p1;
    logic                         nz_p1;
    logic [wlm_qh_w(LOGQ, R)-1:0] qh_p1;

    generate
        if (FF_MUL != 0) begin : g_mul_ff
            always_ff @(posedge clk) begin
                if (rst) begin
                    th_p1   <= '0;
                    prod_p1 <= '0;
                    nz_p1   <= 1'b0;
                    qh_p1   <= '0;
                end else begin
                    th_p1   <= th_p0;
                    prod_p1 <= prod_p0;
                    nz_p1   <= nz_p0;
                    qh_p1   <= qh_in;
                end
            end
        end else begin : g_mul_comb
            assign th_p1   = th_p0;
            assign prod_p1 = prod_p0;
            assign nz_p1   = nz_p0;
            assign qh_p1   = qh_in;
        end
    endgenerate

    // ---- stage p2: after the iteration sum ----
    logic [W-1:0] sum_p1;

    assign sum_p1 = W'(th_p1) + W'(prod_p1) + W'(nz_p1);

    generate
        if (FF_SUM != 0) begin : g_sum_ff
            always_ff @(posedge clk) begin
                if (rst) begin
                    t_out  <= '0;
                    qh_out <= '0;
                end else begin
                    t_out  <= sum_p1;
                    qh_out <= qh_p1;
                end
            end
        end else begin : g_sum_comb
            assign t_out  = sum_p1;
            assign qh_out = qh_p1;
        end
    endgenerate

endmodule

// File: rtl/wlm_reduce.sv
// Pipelined word-level Montgomery reduction T = C * 2^(-R*L) mod q, q = qH*2^R + 1.
// Optional WLM_VALID_EN adds i_valid/o_valid, a LAT-deep valid shift register.
module wlm_reduce
    import wlm_pkg::*;
#(
    parameter int LOGQ    = WLM_DEF_LOGQ,
    parameter int R       = WLM_DEF_R,
    parameter int CORRECT = 1,
    parameter int FF_IN   = 1,
    parameter int FF_MUL  = 1,
    parameter int FF_SUM  = 1,
    parameter int FF_SUB  = 1,
    parameter int FF_OUT  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [wlm_qh_w(LOGQ, R)-1:0]  qH,
    input  logic [2*LOGQ-1:0]             C,
    output logic [LOGQ-1:0]               T
`ifdef WLM_VALID_EN
    ,
    input  logic                          i_valid,
    output logic                          o_valid
`endif
);

    localparam int L   = wlm_calc_l(LOGQ, R);
    localparam int LAT = wlm_calc_lat(L, FF_IN, FF_MUL, FF_SUM, CORRECT, FF_SUB, FF_OUT);
    localparam int W   = 2 * LOGQ;
    localparam int AW  = wlm_acc_w(LOGQ);
    localparam int QHW = wlm_qh_w(LOGQ, R);

    function automatic logic [AW-1:0] cond_sub(input logic [AW-1:0] a, input logic [AW-1:0] q);
        return (a >= q) ? (a - q) : a;
    endfunction

    logic [W-1:0]   t_chain  [0:L];
    logic [QHW-1:0] qh_chain [0:L];

    // ---- stage p0: input register ----
    generate
        if (FF_IN != 0) begin : g_in_ff
            always_ff @(posedge clk) begin
                if (rst) begin
                    t_chain[0]  <= '0;
                    qh_chain[0] <= '0;
                end else begin
                    t_chain[0]  <= C;
                    qh_chain[0] <= qH;
                end
            end
        end else begin : g_in_comb
            assign t_chain[0]  = C;
            assign qh_chain[0] = qH;
        end
    endgenerate

    generate
        for (genvar i = 0; i < L; i++) begin : g_iter
            wlm_iter #(
                .LOGQ   (LOGQ),
                .R      (R),
                .W      (W),
                .FF_MUL (FF_MUL),
                .FF_SUM (FF_SUM)
            ) u_iter (
                .clk    (clk),
                .rst    (rst),
                .t_in   (t_chain[i]),
                .qh_in  (qh_chain[i]),
                .t_out  (t_chain[i+1]),
                .qh_out (qh_chain[i+1])
            );
        end
    endgenerate

    // ---- stage p1: final correction ----
    logic [AW-1:0] acc_p0;
    logic [AW-1:0] res_p1;
    logic          unused_hi;

    // After L iterations the value is below 2q, so LOGQ+1 bits hold it
    assign acc_p0    = t_chain[L][AW-1:0];
    assign unused_hi = ^{t_chain[L][W-1:AW], res_p1[AW-1]};

    generate
        if (CORRECT != 0) begin : g_corr
            logic [AW-1:0] q_full;
            logic [AW-1:0] sub_p0;

            assign q_full = {1'b0, qh_chain[L], R'(1)};
            assign sub_p0 = cond_sub(acc_p0, q_full);

            if (FF_SUB != 0) begin : g_sub_ff
                always_ff @(posedge clk) begin
                    if (rst) res_p1 <= '0;
                    else     res_p1 <= sub_p0;
                end
            end else begin : g_sub_comb
                assign res_p1 = sub_p0;
            end
        end else begin : g_nocorr
            logic unused_qh;

            assign unused_qh = ^qh_chain[L];
            assign res_p1    = acc_p0;
        end
    endgenerate

    // ---- stage p2: output register ----
    generate
        if (FF_OUT != 0) begin : g_out_ff
            always_ff @(posedge clk) begin
                if (rst) T <= '0;
                else     T <= res_p1[LOGQ-1:0];
            end
        end else begin : g_out_comb
            assign T = res_p1[LOGQ-1:0];
        end
    endgenerate

`ifdef WLM_VALID_EN
    generate
        if (LAT == 0) begin : g_vld_comb
            assign o_valid = i_valid;
        end else begin : g_vld_sr
            logic [LAT-1:0] vld_p0;

            always_ff @(posedge clk) begin
                if (rst) vld_p0 <= '0;
                else     vld_p0 <= (vld_p0 << 1) | LAT'(i_valid);
            end
            assign o_valid = vld_p0[LAT-1];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_wlm_reduce.sv
// Directed self-checking bench for wlm_reduce (default build and WLM_VALID_EN build).
module tb_wlm_reduce;

    localparam logic [63:0]  Q1   = 64'h800a000000000001;
    localparam logic [46:0]  QH1  = 47'h400500000000;
    localparam logic [63:0]  Q2   = 64'h0000000000020001;
    localparam logic [46:0]  QH2  = 47'h1;
    localparam logic [127:0] P68  = 128'd1 << 68;
    localparam logic [127:0] BND2 = 128'h0000000000020000_FFFFFFFFFFFFFFFF;

    logic         clk;
    logic         rst;
    logic [46:0]  qH;
    logic [127:0] C;
    logic [63:0]  T;
    logic [63:0]  T0;
    logic         i_valid;
    logic         o_valid;
    logic         o_valid0;

    int errors = 0;
    int checks = 0;

    wlm_reduce dut (
        .clk     (clk),
        .rst     (rst),
        .qH      (qH),
        .C       (C),
        .T       (T)
`ifdef WLM_VALID_EN
        ,
        .i_valid (i_valid),
        .o_valid (o_valid)
`endif
    );

    wlm_reduce #(.CORRECT(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .qH      (qH),
        .C       (C),
        .T       (T0)
`ifdef WLM_VALID_EN
        ,
        .i_valid (i_valid),
        .o_valid (o_valid0)
`endif
    );

`ifndef WLM_VALID_EN
    assign o_valid  = 1'b0;
    assign o_valid0 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; C = '0; qH = '0; i_valid = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        checks++;
        if (T !== 64'd0) begin errors++; $display("FAIL reset_T got=%h want=0", T); end
        checks++;
        if (T0 !== 64'd0) begin errors++; $display("FAIL reset_T0 got=%h want=0", T0); end
        rst = 1'b0;
        tick();
        checks++;
        if (T !== 64'd0) begin errors++; $display("FAIL post_reset_T got=%h want=0", T); end
    endtask

    task automatic test_single();
        logic [127:0] cv [4];
        logic [63:0]  ev [4];
        cv[0] = '0;      ev[0] = 64'd0;
        cv[1] = P68;     ev[1] = 64'd1;
        cv[2] = P68 * 5; ev[2] = 64'd5;
        cv[3] = {64'd0, Q1}; ev[3] = 64'd0;
        for (int v = 0; v < 4; v++) begin
            C = cv[v]; qH = QH1; i_valid = 1'b1;
            for (int n = 1; n <= dut.LAT; n++) begin
                tick();
                C = '0; i_valid = 1'b0;
                if (n == dut.LAT - 1) begin
                    checks++;
                    if (T !== 64'd0) begin
                        errors++; $display("FAIL single_early v=%0d got=%h want=0", v, T);
                    end
                end
                if (n == dut.LAT) begin
                    checks++;
                    if (T !== ev[v]) begin
                        errors++; $display("FAIL single v=%0d got=%h want=%h", v, T, ev[v]);
                    end
                end
            end
        end
    endtask

    task automatic test_nocorrect();
        C = {64'd0, Q1}; qH = QH1;
        for (int n = 1; n <= dut.LAT; n++) begin
            tick();
            C = '0;
            if (n == dut0.LAT) begin
                checks++;
                if (T0 !== Q1) begin
                    errors++; $display("FAIL nocorrect_q got=%h want=%h", T0, Q1);
                end
            end
            if (n == dut.LAT) begin
                checks++;
                if (T !== 64'd0) begin
                    errors++; $display("FAIL correct_q got=%h want=0", T);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] cv [3];
        logic [63:0]  ev [3];
        int j;
        cv[0] = P68;          ev[0] = 64'd1;
        cv[1] = {64'd0, Q1};  ev[1] = 64'd0;
        cv[2] = P68 * 3;      ev[2] = 64'd3;
        for (int n = 0; n < 3 + dut.LAT - 1; n++) begin
            if (n < 3) begin C = cv[n]; qH = QH1; i_valid = 1'b1; end
            else begin C = '0; qH = QH1; i_valid = 1'b0; end
            tick();
            if (n >= dut.LAT - 1) begin
                j = n - (dut.LAT - 1);
                checks++;
                if (T !== ev[j]) begin
                    errors++; $display("FAIL b2b j=%0d got=%h want=%h", j, T, ev[j]);
                end
`ifdef WLM_VALID_EN
                checks++;
                if (o_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_valid j=%0d got=%b want=1", j, o_valid);
                end
`endif
            end
        end
    endtask

    task automatic test_mixed_modulus();
        logic [127:0] cv [7];
        logic [46:0]  qv [7];
        logic [63:0]  ev [7];
        int j;
        // 2^68 = (2^17)^4 = 1 mod Q2, so small C reduces to C mod Q2
        cv[0] = P68;            qv[0] = QH1; ev[0] = 64'd1;
        cv[1] = 128'd200000;    qv[1] = QH2; ev[1] = 64'd68927;
        cv[2] = P68 * 5;        qv[2] = QH1; ev[2] = 64'd5;
        cv[3] = {64'd0, Q2};    qv[3] = QH2; ev[3] = 64'd0;
        cv[4] = {64'd0, Q1};    qv[4] = QH1; ev[4] = 64'd0;
        cv[5] = 128'd12345;     qv[5] = QH2; ev[5] = 64'd12345;
        cv[6] = BND2;           qv[6] = QH2; ev[6] = 64'h20000;
        for (int n = 0; n < 7 + dut.LAT - 1; n++) begin
            if (n < 7) begin C = cv[n]; qH = qv[n]; end
            else begin C = '0; qH = QH1; end
            tick();
            if (n >= dut.LAT - 1) begin
                j = n - (dut.LAT - 1);
                checks++;
                if (T !== ev[j]) begin
                    errors++; $display("FAIL mixed j=%0d got=%h want=%h", j, T, ev[j]);
                end
            end
        end
    endtask

    task automatic test_reset_flight();
        C = P68; qH = QH1; i_valid = 1'b1;
        for (int n = 0; n < dut.LAT + 4; n++) begin
            tick();
            C = '0; i_valid = 1'b0;
            rst = (n == 1 || n == 2);
            checks++;
            if (T !== 64'd0) begin
                errors++; $display("FAIL flight_T n=%0d got=%h want=0", n, T);
            end
`ifdef WLM_VALID_EN
            checks++;
            if (o_valid !== 1'b0) begin
                errors++; $display("FAIL flight_valid n=%0d got=%b want=0", n, o_valid);
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; C = '0; qH = '0; i_valid = 1'b0;
        test_reset();
        test_single();
        test_nocorrect();
        test_back_to_back();
        test_mixed_modulus();
        test_reset_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
